// File: rtl/debug_result_serializer.sv
// debug_result_serializer
//   Takes one debug read result (32-bit value plus 2-bit byte-count code) and
//   streams it to the UART transmitter as a sequence of bytes over a
//   valid/ready byte interface. Only one request is in flight at a time.
//
//   Parameters:
//     MSB_FIRST - 0: least-significant byte first; 1: most-significant valid byte first.
//     IDLE_GAP  - idle cycles with tx_valid low between consecutive data bytes (0-255).
//
//   Optional feature (compile-time macro DEBUG_SERIALIZER_CHECKSUM_EN):
//     When defined, one extra byte follows the data bytes: the XOR of all data
//     bytes of that request. It is sent directly after the last data byte.
//     When undefined, done follows the last data byte.

module debug_result_serializer #(
    parameter int MSB_FIRST = 0,
    parameter int IDLE_GAP  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] result,
    input  logic [1:0]  size,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
`ifdef DEBUG_SERIALIZER_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd5;
`endif

    // Last value of the gap counter before returning to SEND.
    localparam logic [7:0] GAP_LAST = 8'(IDLE_GAP - 1);

    logic [2:0]  state;
    logic [31:0] shreg;      // bytes still to be presented, aligned at the output end
    logic [1:0]  cnt;        // bytes remaining after the one currently on tx_data
    logic [7:0]  gap_cnt;
`ifdef DEBUG_SERIALIZER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic        accept;
    logic [31:0] load_word;
    logic [7:0]  head;
    logic [31:0] shifted;

    assign accept = req_valid && req_ready;

    // Align the request so the first byte to send sits at the output end of the
    // shift register; for MSB-first the top valid byte is moved to bits [31:24],
    // which also discards bytes above the size range.
    always_comb begin
        // NOTE: load_word gets a default before the conditional so no latch is inferred.
        load_word = result;
        if (MSB_FIRST != 0) begin
            load_word = result << {~size, 3'b000};
        end
    end

    // Next byte to present and the register contents after removing it.
    assign head    = (MSB_FIRST != 0) ? shreg[31:24] : shreg[7:0];
    assign shifted = (MSB_FIRST != 0) ? (shreg << 8) : (shreg >> 8);

    // Main sequencer: request capture, byte presentation, handshakes and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            shreg     <= 32'h0;
            cnt       <= 2'd0;
            gap_cnt   <= 8'd0;
`ifdef DEBUG_SERIALIZER_CHECKSUM_EN
            csum      <= 8'h00;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the
            // pre-edge values; done defaults low here and is a single-cycle pulse.
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        shreg     <= load_word;
                        cnt       <= size;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    tx_data  <= head;
                    tx_valid <= 1'b1;
                    shreg    <= shifted;
`ifdef DEBUG_SERIALIZER_CHECKSUM_EN
                    csum     <= head;
`endif
                    state    <= S_SEND;
                end

                S_SEND: begin
                    if (tx_ready) begin
                        if (cnt == 2'd0) begin
`ifdef DEBUG_SERIALIZER_CHECKSUM_EN
                            // tx_valid stays high; the checksum replaces the last data byte.
                            tx_data <= csum;
                            state   <= S_CHK;
`else
                            tx_valid  <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                            state     <= S_DONE;
`endif
                        end else begin
                            cnt <= cnt - 2'd1;
                            if (IDLE_GAP == 0) begin
                                tx_data <= head;
                                shreg   <= shifted;
`ifdef DEBUG_SERIALIZER_CHECKSUM_EN
                                csum    <= csum ^ head;
`endif
                            end else begin
                                tx_valid <= 1'b0;
                                gap_cnt  <= 8'd0;
                                state    <= S_GAP;
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        tx_data  <= head;
                        tx_valid <= 1'b1;
                        shreg    <= shifted;
`ifdef DEBUG_SERIALIZER_CHECKSUM_EN
                        csum     <= csum ^ head;
`endif
                        state    <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

`ifdef DEBUG_SERIALIZER_CHECKSUM_EN
                S_CHK: begin
                    if (tx_ready) begin
                        tx_valid  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    // req_ready is already high, so a new request can be taken here.
                    if (accept) begin
                        shreg     <= load_word;
                        cnt       <= size;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_result_serializer.sv
// tb_debug_result_serializer
//   Two serializer instances: u_lsb (LSB first, no gap) and u_msb (MSB first,
//   gap of GAP1 cycles). Expected byte streams are derived from result/size
//   with plain arithmetic; inputs are driven and outputs sampled on negedges.

module tb_debug_result_serializer;

    localparam int GAP1 = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  tx_valid;
    logic [1:0]  tx_ready;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [31:0] result  [2];
    logic [1:0]  size    [2];
    logic [7:0]  tx_data [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    debug_result_serializer #(.MSB_FIRST(0), .IDLE_GAP(0)) u_lsb (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .result(result[0]), .size(size[0]),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .busy(busy[0]), .done(done[0])
    );

    debug_result_serializer #(.MSB_FIRST(1), .IDLE_GAP(GAP1)) u_msb (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .result(result[1]), .size(size[1]),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One request on instance d; mode 0 = tx_ready always high, 1 = random
    // tx_ready, 2 = five stall cycles per byte. Called and returns on a negedge.
    task automatic do_txn(input int d, input logic [31:0] r, input logic [1:0] s, input int mode);
        logic [7:0] exp_q[$];
        logic [7:0] x;
        logic [7:0] held;
        int         n_data, idx, cyc, first_valid, stall, gap_low, gap_exp;
        bit         pend, fin, lat_chk;

        // Reference stream: byte k of result is r[8k+7:8k]; order set by instance.
        n_data = int'(s) + 1;
        x = 8'h00;
        for (int i = 0; i < n_data; i++) begin
            int k;
            k = (d == 1) ? (n_data - 1 - i) : i;
            exp_q.push_back(r[8*k +: 8]);
            x = x ^ r[8*k +: 8];
        end
`ifdef DEBUG_SERIALIZER_CHECKSUM_EN
        exp_q.push_back(x);
`endif

        cyc = 0;
        while (req_ready[d] !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ready_before_req", req_ready[d], 1);
        req_valid[d] = 1'b1;
        result[d]    = r;
        size[d]      = s;
        @(negedge clk);
        req_valid[d] = 1'b0;
        result[d]    = $urandom;
        size[d]      = 2'($urandom);
        check("busy_after_accept", busy[d], 1);
        check("req_ready_after_accept", req_ready[d], 0);

        idx = 0; cyc = 0; first_valid = -1; stall = 0; gap_low = 0;
        pend = 0; fin = 0; held = 8'h00;
        lat_chk = (d == 0) && (mode == 0);
        while (!fin && cyc < 300) begin
            cyc++;
            @(negedge clk);
            if (idx == exp_q.size()) begin
                check("done_pulse", done[d], 1);
                check("busy_at_done", busy[d], 0);
                check("req_ready_at_done", req_ready[d], 1);
                check("tx_valid_at_done", tx_valid[d], 0);
                if (lat_chk) check("done_latency", cyc, 1 + exp_q.size());
                tx_ready[d] = 1'b0;
                fin = 1;
            end else begin
                check("no_early_done", done[d], 0);
                check("busy_in_flight", busy[d], 1);
                check("req_ready_in_flight", req_ready[d], 0);
                if (pend) begin
                    check("hold_valid", tx_valid[d], 1);
                    check("hold_data", tx_data[d], held);
                end
                if (tx_valid[d]) begin
                    if (!pend) begin
                        if (first_valid < 0) begin
                            first_valid = cyc;
                            if (lat_chk) check("first_valid_latency", cyc, 1);
                        end else begin
                            gap_exp = (idx >= n_data || d == 0) ? 0 : GAP1;
                            check("gap_cycles", gap_low, gap_exp);
                        end
                    end
                    case (mode)
                        0: tx_ready[d] = 1'b1;
                        1: tx_ready[d] = 1'($urandom_range(0, 1));
                        default: begin
                            if (stall < 5) begin
                                tx_ready[d] = 1'b0;
                                stall++;
                            end else begin
                                tx_ready[d] = 1'b1;
                            end
                        end
                    endcase
                    if (tx_ready[d]) begin
                        check("byte", tx_data[d], exp_q[idx]);
                        idx++;
                        pend = 0;
                        stall = 0;
                        gap_low = 0;
                    end else begin
                        pend = 1;
                        held = tx_data[d];
                    end
                end else begin
                    if (first_valid >= 0) gap_low++;
                    tx_ready[d] = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
        end
        if (!fin) check("txn_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int got_first;

        // Reset held with requests pending: everything must stay quiet.
        reset     = 1'b0;
        req_valid = 2'b11;
        tx_ready  = 2'b11;
        result[0] = $urandom; result[1] = $urandom;
        size[0]   = 2'd3;     size[1]   = 2'd3;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_req_ready", req_ready[d], 0);
            check("rst_tx_valid", tx_valid[d], 0);
            check("rst_tx_data", tx_data[d], 0);
            check("rst_busy", busy[d], 0);
            check("rst_done", done[d], 0);
        end
        reset     = 1'b1;
        req_valid = 2'b00;
        tx_ready  = 2'b00;
        @(negedge clk);
        check("req_ready_after_reset_lsb", req_ready[0], 1);
        check("req_ready_after_reset_msb", req_ready[1], 1);

        // Directed cases; consecutive calls also exercise accept in the done cycle.
        do_txn(0, 32'hDEADBEEF, 2'd3, 0);
        do_txn(0, 32'hDEADBEEF, 2'd3, 0);
        do_txn(1, 32'h12345678, 2'd0, 0);
        do_txn(1, 32'h0000A55A, 2'd1, 0);
        do_txn(0, 32'h00332211, 2'd2, 2);
        do_txn(1, 32'hCAFEF00D, 2'd3, 2);

        // Reset in the middle of a 4-byte request, after the first byte.
        req_valid[0] = 1'b1; result[0] = 32'h44332211; size[0] = 2'd3;
        @(negedge clk);
        req_valid[0] = 1'b0;
        tx_ready[0]  = 1'b1;
        got_first = 0;
        for (int i = 0; i < 10 && !got_first; i++) begin
            @(negedge clk);
            if (tx_valid[0]) got_first = 1;
        end
        check("mid_rst_first_byte_seen", got_first, 1);
        @(negedge clk);
        check("mid_rst_second_byte_valid", tx_valid[0], 1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_tx_valid", tx_valid[0], 0);
        check("mid_rst_busy", busy[0], 0);
        check("mid_rst_done", done[0], 0);
        check("mid_rst_req_ready", req_ready[0], 0);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_no_done", done[0], 0);
        end
        reset = 1'b1;
        tx_ready[0] = 1'b0;
        @(negedge clk);
        check("mid_rst_no_done_after", done[0], 0);
        check("mid_rst_req_ready_back", req_ready[0], 1);
        do_txn(0, 32'h0000005A, 2'd0, 0);

        // Randomized requests on both instances.
        for (int n = 0; n < 40; n++) begin
            do_txn(int'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
